// File: rtl/hamming_match_scanner_if.sv
// hamming_match_scanner_if: start/key/thr command, valid/ready word stream and result bundle; master drives, slave is the scanner
interface hamming_match_scanner_if;
  logic       start;
  logic [3:0] key;
  logic [2:0] thr;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic       busy;
  logic       done;
  logic [2:0] best_score;
  logic [3:0] best_idx;
  logic [4:0] hit_count;
  modport master (
    output start, key, thr, in_valid, in_data,
    input  in_ready, busy, done, best_score, best_idx, hit_count
  );
  modport slave (
    input  start, key, thr, in_valid, in_data,
    output in_ready, busy, done, best_score, best_idx, hit_count
  );
endinterface

// File: rtl/hamming_match_scanner.sv
// hamming_match_scanner: scans N_WORDS words for best bitwise similarity to a key and counts threshold hits; ports clk, rst, bus (slave)
module hamming_match_scanner #(
  parameter int N_WORDS = 8
) (
  input logic                    clk,
  input logic                    rst,
  hamming_match_scanner_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
  state_e     state_q, state_d;
  logic [3:0] key_q, key_d;
  logic [2:0] thr_q, thr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] best_score_q, best_score_d;
  logic [3:0] best_idx_q, best_idx_d;
  logic [4:0] hit_count_q, hit_count_d;
  logic [3:0] eq;
  logic [2:0] score;
  assign eq    = ~(key_q ^ bus.in_data);
  assign score = 3'(eq[0]) + 3'(eq[1]) + 3'(eq[2]) + 3'(eq[3]);
  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    thr_d        = thr_q;
    cnt_d        = cnt_q;
    best_score_d = best_score_q;
    best_idx_d   = best_idx_q;
    hit_count_d  = hit_count_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d      = SCAN;
        key_d        = bus.key;
        thr_d        = bus.thr;
        cnt_d        = '0;
        best_score_d = '0;
        best_idx_d   = '0;
        hit_count_d  = '0;
      end
      SCAN: if (bus.in_valid) begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd0 || score > best_score_q) begin
          best_score_d = score;
          best_idx_d   = cnt_q;
        end
        if (score >= thr_q) hit_count_d = hit_count_q + 5'd1;
        if (cnt_q == 4'(N_WORDS - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      key_q        <= '0;
      thr_q        <= '0;
      cnt_q        <= '0;
      best_score_q <= '0;
      best_idx_q   <= '0;
      hit_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      key_q        <= key_d;
      thr_q        <= thr_d;
      cnt_q        <= cnt_d;
      best_score_q <= best_score_d;
      best_idx_q   <= best_idx_d;
      hit_count_q  <= hit_count_d;
    end
  end
  assign bus.in_ready   = state_q == SCAN;
  assign bus.busy       = state_q != IDLE;
  assign bus.done       = state_q == DONE;
  assign bus.best_score = best_score_q;
  assign bus.best_idx   = best_idx_q;
  assign bus.hit_count  = hit_count_q;
endmodule

// File: tb/tb_hamming_match_scanner.sv
// tb_hamming_match_scanner: scoreboard-driven checks of reset, scans, stalls, ignored start and mid-scan reset
module tb_hamming_match_scanner;
  localparam int N = 8;
  logic clk = 0;
  logic rst = 1;
  hamming_match_scanner_if bus ();
  hamming_match_scanner #(.N_WORDS(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {int sc; int idx; int hits; int cyc;} exp_t;
  typedef struct {int sc; int idx; int hits; int cyc; bit ready_bad; bit done2; bit busy2;} obs_t;
  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  typedef logic [3:0] words_t [N];
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  function automatic exp_t model(input logic [3:0] k, input logic [2:0] t, input words_t w, input int cyc);
    exp_t e;
    e = '{0, 0, 0, cyc};
    for (int i = 0; i < N; i++) begin
      int s = 0;
      for (int b = 0; b < 4; b++) s += (k[b] == w[i][b]) ? 1 : 0;
      if (i == 0 || s > e.sc) begin
        e.sc  = s;
        e.idx = i;
      end
      if (s >= int'(t)) e.hits++;
    end
    return e;
  endfunction
  task automatic run_scan(input logic [3:0] k, input logic [2:0] t, input words_t w, input bit stall,
                          input bit mid_start, output obs_t o);
    int cyc, i;
    bit v;
    o.ready_bad = 0;
    bus.start = 1; bus.key = k; bus.thr = t;
    tick;
    bus.start = 0;
    cyc = 1; i = 0;
    while (!bus.done && cyc < 100) begin
      if (!bus.in_ready) o.ready_bad = 1;
      v = !stall || cyc[0];
      bus.in_valid = v && i < N;
      bus.in_data  = bus.in_valid ? w[i] : 4'($urandom);
      if (bus.in_valid) i++;
      bus.start = mid_start && (cyc == 3 || cyc == 5);
      bus.key   = ~k;
      bus.thr   = 3'd0;
      tick;
      cyc++;
    end
    bus.in_valid = 0; bus.start = 0;
    o.cyc = cyc; o.sc = int'(bus.best_score); o.idx = int'(bus.best_idx); o.hits = int'(bus.hit_count);
    tick;
    o.done2 = bus.done; o.busy2 = bus.busy;
  endtask
  task automatic check_scan(input string name, input obs_t o);
    exp_t e;
    e = sb.pop_front();
    n_cmp++; if (o.cyc !== e.cyc) begin n_bad++; $display("FAIL %s done_cycle got %0d want %0d", name, o.cyc, e.cyc); end
    n_cmp++; if (o.sc !== e.sc) begin n_bad++; $display("FAIL %s best_score got %0d want %0d", name, o.sc, e.sc); end
    n_cmp++; if (o.idx !== e.idx) begin n_bad++; $display("FAIL %s best_idx got %0d want %0d", name, o.idx, e.idx); end
    n_cmp++; if (o.hits !== e.hits) begin n_bad++; $display("FAIL %s hit_count got %0d want %0d", name, o.hits, e.hits); end
    n_cmp++; if (o.ready_bad !== 1'b0) begin n_bad++; $display("FAIL %s in_ready_low_in_scan got %0d want 0", name, o.ready_bad); end
    n_cmp++; if ({o.done2, o.busy2} !== 2'b00) begin n_bad++; $display("FAIL %s after_done done/busy got %b want 00", name, {o.done2, o.busy2}); end
  endtask
  words_t basic_w = '{4'b1010, 4'b0101, 4'b1011, 4'b1110, 4'b1010, 4'b0000, 4'b1111, 4'b0010};
  words_t late_w  = '{4'b1111, 4'b0111, 4'b0011, 4'b0011, 4'b1111, 4'b0001, 4'b0001, 4'b1000};
  task automatic test_reset;
    rst = 1;
    repeat (2) begin
      bus.start = 1'($urandom); bus.key = 4'($urandom); bus.thr = 3'($urandom);
      bus.in_valid = 1'($urandom); bus.in_data = 4'($urandom);
      tick;
    end
    n_cmp++;
    if ({bus.in_ready, bus.busy, bus.done, bus.best_score, bus.best_idx, bus.hit_count} !== 15'd0) begin
      n_bad++; $display("FAIL reset_outputs got %b want 0", {bus.in_ready, bus.busy, bus.done, bus.best_score, bus.best_idx, bus.hit_count});
    end
    rst = 0; bus.start = 0; bus.in_valid = 1; bus.in_data = 4'b0000; bus.key = 4'b0000; bus.thr = 3'd0;
    repeat (3) begin
      tick;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL idle_in_ready got %b want 0", bus.in_ready); end
    end
    n_cmp++;
    if ({bus.busy, bus.hit_count} !== 6'd0) begin n_bad++; $display("FAIL idle_no_consume busy/hits got %b want 0", {bus.busy, bus.hit_count}); end
    bus.in_valid = 0;
  endtask
  task automatic test_basic;
    obs_t o;
    sb.push_back('{4, 0, 5, N + 1});
    run_scan(4'b1010, 3'd3, basic_w, 0, 0, o);
    check_scan("basic", o);
  endtask
  task automatic test_late_best;
    obs_t o;
    sb.push_back('{3, 5, 8, N + 1});
    run_scan(4'b0000, 3'd0, late_w, 0, 0, o);
    check_scan("late_best", o);
  endtask
  task automatic test_stalls;
    obs_t o;
    sb.push_back('{4, 0, 5, 2 * N});
    run_scan(4'b1010, 3'd3, basic_w, 1, 0, o);
    check_scan("stalls", o);
  endtask
  task automatic test_high_thr;
    obs_t o;
    sb.push_back('{3, 5, 0, N + 1});
    run_scan(4'b0000, 3'd5, late_w, 0, 0, o);
    check_scan("thr5", o);
  endtask
  task automatic test_start_ignored;
    obs_t o;
    sb.push_back('{4, 0, 5, N + 1});
    run_scan(4'b1010, 3'd3, basic_w, 0, 1, o);
    check_scan("mid_start", o);
    bus.start = 1; bus.key = 4'b0000; bus.thr = 3'd0;
    tick;
    bus.start = 0;
    n_cmp++;
    if ({bus.busy, bus.in_ready, bus.best_score, bus.best_idx, bus.hit_count} !== 14'b11_000_0000_00000) begin
      n_bad++; $display("FAIL restart_clear got %b want 11000000000000", {bus.busy, bus.in_ready, bus.best_score, bus.best_idx, bus.hit_count});
    end
    bus.in_valid = 1;
    for (int i = 0; i < N; i++) begin bus.in_data = late_w[i]; tick; end
    bus.in_valid = 0;
    n_cmp++;
    if ({bus.done, bus.best_score, bus.best_idx, bus.hit_count} !== {1'b1, 3'd3, 4'd5, 5'd8}) begin
      n_bad++; $display("FAIL restart_scan got %b want %b", {bus.done, bus.best_score, bus.best_idx, bus.hit_count}, {1'b1, 3'd3, 4'd5, 5'd8});
    end
    tick;
  endtask
  task automatic test_rst_mid;
    obs_t o;
    words_t w;
    logic [3:0] k;
    logic [2:0] t;
    bit saw_done;
    bus.start = 1; bus.key = 4'b1010; bus.thr = 3'd0;
    tick;
    bus.start = 0; bus.in_valid = 1;
    for (int i = 0; i < 4; i++) begin bus.in_data = basic_w[i]; tick; end
    n_cmp++; if (bus.hit_count !== 5'd4) begin n_bad++; $display("FAIL pre_rst_hits got %0d want 4", bus.hit_count); end
    rst = 1;
    tick;
    rst = 0;
    n_cmp++;
    if ({bus.in_ready, bus.busy, bus.done, bus.best_score, bus.best_idx, bus.hit_count} !== 15'd0) begin
      n_bad++; $display("FAIL rst_mid_outputs got %b want 0", {bus.in_ready, bus.busy, bus.done, bus.best_score, bus.best_idx, bus.hit_count});
    end
    saw_done = 0;
    repeat (N + 2) begin tick; saw_done |= bus.done; end
    bus.in_valid = 0;
    n_cmp++; if (saw_done !== 1'b0) begin n_bad++; $display("FAIL rst_mid_no_done got %b want 0", saw_done); end
    for (int r = 0; r < 3; r++) begin
      k = 4'($urandom); t = 3'($urandom_range(0, 5));
      foreach (w[i]) w[i] = 4'($urandom);
      sb.push_back(model(k, t, w, N + 1));
      run_scan(k, t, w, r[0], 0, o);
      if (r[0]) o.cyc = o.cyc - (N - 1);
      check_scan($sformatf("rand%0d", r), o);
    end
  endtask
  initial begin
    bus.start = 0; bus.key = 0; bus.thr = 0; bus.in_valid = 0; bus.in_data = 0;
    test_reset;
    test_basic;
    test_late_best;
    test_stalls;
    test_high_thr;
    test_start_ignored;
    test_rst_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/hamming_match_scanner.md
# hamming_match_scanner

- Sequential controller that drives a 4-bit bitwise-similarity computation over a stream of words.
- After `start`, it latches a 4-bit key and a threshold, then accepts exactly `N_WORDS` data words over a valid/ready handshake.
- For each word it computes the similarity: the count of bit positions equal to the key, 0..4.
- It tracks the best score, the index of the first word reaching that score, and the number of words at or above the threshold. It signals completion with a one-cycle `done` pulse.
- It is the sequencing layer that turns the combinational similarity function into a pattern-search unit for lab datapaths.

## Interface

Parameters:
- `N_WORDS`, default 8: words per scan. Legal range 2..16.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: begin a scan. Sampled only in IDLE.
- `key` input 4: pattern, latched on accepted `start`.
- `thr` input 3: hit threshold 0..4, latched on accepted `start`. Values 5..7 give zero hits.
- `in_valid` input 1: `in_data` is valid.
- `in_data` input 4: word to compare.
- `in_ready` output 1: block accepts a word this cycle.
- `busy` output 1: high in SCAN and DONE.
- `done` output 1: one-cycle completion pulse.
- `best_score` output 3: highest similarity seen, 0..4.
- `best_idx` output 4: index (0-based, arrival order) of the first word achieving `best_score`.
- `hit_count` output 5: number of words with score ≥ threshold, 0..16.

## Operation

States and transitions:
- IDLE → SCAN on `start`=1.
- SCAN → DONE when the `N_WORDS`-th word is accepted.
- DONE → IDLE unconditionally.

Entering SCAN:
- Latch `key` and `thr`.
- Clear `best_score`, `best_idx`, `hit_count` and the internal word counter (`cnt`, 4 bits).

In SCAN:
- `in_ready`=1. A word is accepted when `in_valid` and `in_ready` are both 1.
- score = 4 − popcount(key_q XOR in_data), computed internally as 3-bit unsigned.
- First accepted word (`cnt`=0): unconditionally loads `best_score`=score and `best_idx`=0.
- Later words: update best only if score > `best_score` (strictly greater). Ties keep the earlier index.
- If score ≥ thr_q, increment `hit_count`. It cannot overflow because it is at most 16.
- `cnt` increments per accepted word. On the accept with `cnt`=`N_WORDS`−1, go to DONE.

Other rules:
- `in_ready`=0 in IDLE and DONE; words presented there are not consumed.
- `start` is ignored in SCAN and DONE; it neither restarts nor re-latches.
- Results hold after DONE until the next accepted `start` clears them.

Reset:
- `rst` in any state, including mid-scan, forces IDLE on the next edge.
- Reset values: `in_ready`=0, `busy`=0, `done`=0, `best_score`=0, `best_idx`=0, `hit_count`=0.
- Partial results are discarded.

## Timing

- All outputs are registered except `in_ready`, which is decoded from state only (no combinational path from `in_valid`).
- `start` sampled at edge E0: SCAN from cycle 1, and `in_ready` is high in cycle 1.
- Result registers update on the edge that accepts the word. Values are visible the cycle after.
- With `in_valid` held high, words are accepted in cycles 1..`N_WORDS`.
- `done`=1 and final results are valid in cycle `N_WORDS`+1. The block is in IDLE in cycle `N_WORDS`+2, so minimum scan-to-scan spacing is `N_WORDS`+2 cycles.
- Stalls (`in_valid`=0) extend SCAN by one cycle each. There is no timeout.
- `done` is never asserted for more than one cycle. `busy` falls the cycle after `done`.

## Test plan

- Reset: assert `rst` 2 cycles with random inputs → all outputs 0, `in_ready`=0. Drive `in_valid`=1 while IDLE → nothing consumed, `hit_count` stays 0.
- Basic scan, `N_WORDS`=8, `key`=1010, `thr`=3, back-to-back words 1010, 0101, 1011, 1110, 1010, 0000, 1111, 0010 (scores 4,0,3,3,4,2,2,3) → `done` in cycle 9, `best_score`=4, `best_idx`=0, `hit_count`=5.
- Late best with ties, `key`=0000, `thr`=0, words 1111, 0111, 0011, 0011, 1111, 0001, 0001, 1000 → `best_score`=3, `best_idx`=5, `hit_count`=8.
- Stalls: basic scan with `in_valid` toggled 1/0 every cycle → same results as the basic scan. `done` in cycle 16. `in_ready` stays 1 throughout SCAN.
- `start` pulsed mid-scan with a different key/thr → ignored, results match the original key/thr. `start` pulsed again after `done` → results clear on entry to SCAN.
- `rst` after 4 words accepted → IDLE next cycle, outputs 0, no `done` pulse. A new scan then completes normally.
